alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter PC_RESET, default 64'h0, the program counter value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 1, the PC increment per retired non-branch instruction.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  ALU result bundle valid this cycle.
REQ-006 in_ready  output  1  stage accepts bundle; transfer occurs when in_valid & in_ready.
REQ-007 instr  input  6  opcode accompanying the ALU result.
REQ-008 rd  input  4  destination register index.
REQ-009 alu_c  input  64  ALU result C.
REQ-010 alu_flag  input  1  ALU compare/flag output F3.
REQ-011 addrch  input  1  ALU branch-taken indication.
REQ-012 naddr  input  64  ALU branch target.
REQ-013 rf_we  output  1  register-file write enable, one-cycle pulse.
REQ-014 rf_waddr  output  4  register-file write index.
REQ-015 rf_wdata  output  64  register-file write data.
REQ-016 pc  output  64  current program counter.
REQ-017 flag_f1  output  1  flag F1 fed back to the ALU.
REQ-018 flag_f2  output  1  flag F2 fed back to the ALU.
REQ-019 halted  output  1  high while in HALT state.

Function
REQ-020 SHALL implement states RUN, FLUSH, HALT; reset enters RUN.
REQ-021 In RUN, in_ready SHALL be 1; in FLUSH and HALT, in_ready SHALL be 0.
REQ-022 On transfer with instr in {0,1,2,3,5,16,17}, SHALL assert rf_we on the next cycle with rf_waddr=rd, rf_wdata=alu_c (registered, latency 1).
REQ-023 On transfer with any other instr, rf_we SHALL stay 0; rf_waddr/rf_wdata hold previous values.
REQ-024 On transfer with instr in 8..13, SHALL update flag_f2 <= flag_f1 and flag_f1 <= alu_flag in the same edge.
REQ-025 On transfer with addrch=1, SHALL load pc <= naddr and enter FLUSH for exactly one cycle, then return to RUN.
REQ-026 On transfer with addrch=0 and instr != 63, SHALL load pc <= pc + PC_STEP, modulo 2^64 (wraps from all-ones).
REQ-027 On transfer with instr=63, SHALL enter HALT, hold pc, assert halted; only reset exits HALT.
REQ-028 instr=63 with addrch=1 SHALL be treated as HALT; addrch ignored.
REQ-029 Without transfer (in_valid=0 or in_ready=0), pc, flags and state except FLUSH->RUN SHALL hold; rf_we SHALL be 0.
REQ-030 Bundles presented while in_ready=0 SHALL be ignored, not queued.

Reset
REQ-031 Reset SHALL set pc=PC_RESET, flag_f1=0, flag_f2=0, rf_we=0, rf_waddr=0, rf_wdata=0, halted=0, state=RUN.
REQ-032 Reset SHALL take priority over any simultaneous transfer; a bundle valid on the reset edge is discarded.
REQ-033 Reset asserted in FLUSH or HALT SHALL return to RUN with in_ready=1 the cycle after reset deasserts.

Configuration
REQ-034 With WB_RETIRE_CNT_EN defined, SHALL add output retired [63:0], reset to 0, incremented by 1 on every transfer, wrapping modulo 2^64.
REQ-035 Without WB_RETIRE_CNT_EN, the retired port and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-036 Reset, then transfer instr=0, rd=3, alu_c=64'h1234 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=64'h1234, pc=1.
REQ-037 Transfer instr=14, addrch=1, naddr=64'h40 -> pc=64'h40, in_ready=0 one cycle, then 1; rf_we stays 0.
REQ-038 Transfer instr=8, alu_flag=1, then instr=9, alu_flag=0 -> flag_f1=0, flag_f2=1.
REQ-039 Transfer instr=63 with addrch=1 -> halted=1, pc unchanged, in_ready=0 for 10 cycles; assert reset -> pc=PC_RESET, halted=0.
REQ-040 pc at 64'hFFFF_FFFF_FFFF_FFFF, transfer instr=4, addrch=0 -> pc=0, rf_we=0.
REQ-041 With WB_RETIRE_CNT_EN, five transfers with in_valid gaps and one during FLUSH -> retired=5.

Source files
------------

// File: rtl/alu_writeback_if.sv
// Bundle between the ALU and the writeback stage: result/branch inputs plus
// register-file write, PC and flag feedback.
interface alu_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  instr;
    logic [3:0]  rd;
    logic [63:0] alu_c;
    logic        alu_flag;
    logic        addrch;
    logic [63:0] naddr;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [63:0] pc;
    logic        flag_f1;
    logic        flag_f2;
    logic        halted;

    modport master (
        output in_valid, instr, rd, alu_c, alu_flag, addrch, naddr,
        input  in_ready, rf_we, rf_waddr, rf_wdata, pc, flag_f1, flag_f2, halted
    );

    modport slave (
        input  in_valid, instr, rd, alu_c, alu_flag, addrch, naddr,
        output in_ready, rf_we, rf_waddr, rf_wdata, pc, flag_f1, flag_f2, halted
    );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: register-file write, PC update, flag history, branch flush and halt.
// Optional feature macro WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter.
module alu_writeback #(
    parameter logic [63:0] PC_RESET = 64'h0,
    parameter logic [63:0] PC_STEP  = 64'd1
) (
    input  logic              clock,
    input  logic              reset,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]       retired,
`endif
    alu_writeback_if.slave    wb
);
    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_xfer;
    logic        w_writes_rf;
    logic        w_flag_op;
    logic        w_halt_op;
    logic        r_rf_we;
    logic [3:0]  r_rf_waddr;
    logic [63:0] r_rf_wdata;
    logic [63:0] r_pc;
    logic        r_flag_f1;
    logic        r_flag_f2;

    assign w_xfer    = wb.in_valid && (r_state == ST_RUN);
    assign w_halt_op = (wb.instr == 6'd63);

    always_comb begin
        w_writes_rf = 1'b0;
        w_flag_op   = 1'b0;
        case (wb.instr)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd5, 6'd16, 6'd17: w_writes_rf = 1'b1;
            6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13:     w_flag_op   = 1'b1;
            default: ;
        endcase
    end

    // HALT takes precedence over a simultaneous branch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_xfer) begin
                    if (w_halt_op)
                        w_state_next = ST_HALT;
                    else if (wb.addrch)
                        w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: w_state_next = ST_RUN;
            ST_HALT:  w_state_next = ST_HALT;
            default:  w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 4'd0;
            r_rf_wdata <= 64'd0;
            r_pc       <= PC_RESET;
            r_flag_f1  <= 1'b0;
            r_flag_f2  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rf_we <= w_xfer && w_writes_rf;
            if (w_xfer && w_writes_rf) begin
                r_rf_waddr <= wb.rd;
                r_rf_wdata <= wb.alu_c;
            end
            if (w_xfer && w_flag_op) begin
                r_flag_f2 <= r_flag_f1;
                r_flag_f1 <= wb.alu_flag;
            end
            if (w_xfer && !w_halt_op) begin
                if (wb.addrch)
                    r_pc <= wb.naddr;
                else
                    r_pc <= r_pc + PC_STEP;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_retired;

    always_ff @(posedge clock) begin
        if (reset)
            r_retired <= 64'd0;
        else if (w_xfer)
            r_retired <= r_retired + 64'd1;
    end

    assign retired = r_retired;
`endif

    assign wb.in_ready = (r_state == ST_RUN);
    assign wb.rf_we    = r_rf_we;
    assign wb.rf_waddr = r_rf_waddr;
    assign wb.rf_wdata = r_rf_wdata;
    assign wb.pc       = r_pc;
    assign wb.flag_f1  = r_flag_f1;
    assign wb.flag_f2  = r_flag_f2;
    assign wb.halted   = (r_state == ST_HALT);
endmodule

// File: tb/tb_alu_writeback.sv
// Table-driven bench for alu_writeback with hand-written halt/reset and retire sequences.
module tb_alu_writeback;
    localparam logic [63:0] PC_RST = 64'h100;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retired;
`endif

    alu_writeback_if wb ();

    alu_writeback #(.PC_RESET(PC_RST), .PC_STEP(64'd1)) dut (
        .clock   (clock),
        .reset   (reset),
`ifdef WB_RETIRE_CNT_EN
        .retired (retired),
`endif
        .wb      (wb.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic [5:0]  instr;
        logic [3:0]  rd;
        logic [63:0] alu_c;
        logic        flag;
        logic        addrch;
        logic [63:0] naddr;
        logic        e_we;
        logic [3:0]  e_waddr;
        logic [63:0] e_wdata;
        logic [63:0] e_pc;
        logic        e_f1;
        logic        e_f2;
        logic        e_ready;
        logic        e_halted;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [5:0] ins, input logic [3:0] rd,
                         input logic [63:0] c, input logic f, input logic br,
                         input logic [63:0] na);
        wb.in_valid = v;
        wb.instr    = ins;
        wb.rd       = rd;
        wb.alu_c    = c;
        wb.alu_flag = f;
        wb.addrch   = br;
        wb.naddr    = na;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        //         v  ins  rd  alu_c    f  br naddr   we wa  wdata    pc        f1 f2 rdy hlt
        vecs[0]  = '{1, 0,  3, 64'h1234, 0, 0, 0,      1, 3, 64'h1234, 64'h101,  0, 0, 1, 0};
        vecs[1]  = '{1, 4,  5, 64'h99,   0, 0, 0,      0, 3, 64'h1234, 64'h102,  0, 0, 1, 0};
        vecs[2]  = '{1, 8,  1, 64'h5,    1, 0, 0,      0, 3, 64'h1234, 64'h103,  1, 0, 1, 0};
        vecs[3]  = '{1, 9,  1, 64'h6,    0, 0, 0,      0, 3, 64'h1234, 64'h104,  0, 1, 1, 0};
        vecs[4]  = '{0, 0,  7, 64'h7,    1, 0, 0,      0, 3, 64'h1234, 64'h104,  0, 1, 1, 0};
        vecs[5]  = '{1, 17, 15, ONES,    0, 0, 0,      1, 15, ONES,    64'h105,  0, 1, 1, 0};
        vecs[6]  = '{1, 16, 1, 64'h55,   1, 0, 0,      1, 1, 64'h55,   64'h106,  0, 1, 1, 0};
        vecs[7]  = '{1, 13, 2, 64'h7,    1, 0, 0,      0, 1, 64'h55,   64'h107,  1, 0, 1, 0};
        vecs[8]  = '{1, 5,  4, 64'hABCD, 0, 0, 0,      1, 4, 64'hABCD, 64'h108,  1, 0, 1, 0};
        vecs[9]  = '{1, 14, 8, 64'h1,    0, 1, 64'h40, 0, 4, 64'hABCD, 64'h40,   1, 0, 0, 0};
        vecs[10] = '{1, 0,  9, 64'h77,   0, 0, 0,      0, 4, 64'hABCD, 64'h40,   1, 0, 1, 0};
        vecs[11] = '{1, 2,  6, 64'h66,   0, 0, 0,      1, 6, 64'h66,   64'h41,   1, 0, 1, 0};
        vecs[12] = '{1, 3,  0, 64'h33,   0, 1, ONES,   1, 0, 64'h33,   ONES,     1, 0, 0, 0};
        vecs[13] = '{0, 0,  0, 64'h0,    0, 0, 0,      0, 0, 64'h33,   ONES,     1, 0, 1, 0};
        vecs[14] = '{1, 4,  2, 64'h44,   0, 0, 0,      0, 0, 64'h33,   64'h0,    1, 0, 1, 0};
        vecs[15] = '{1, 63, 5, 64'h88,   0, 1, 64'h1000, 0, 0, 64'h33, 64'h0,    1, 0, 0, 1};

        wb.in_valid = 1'b1;
        wb.instr    = 6'd0;
        wb.rd       = 4'd9;
        wb.alu_c    = 64'hDEAD;
        wb.alu_flag = 1'b1;
        wb.addrch   = 1'b0;
        wb.naddr    = 64'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_pc", wb.pc, PC_RST);
        check("rst_we", 64'(wb.rf_we), 64'd0);
        check("rst_waddr", 64'(wb.rf_waddr), 64'd0);
        check("rst_wdata", wb.rf_wdata, 64'd0);
        check("rst_flags", {62'd0, wb.flag_f1, wb.flag_f2}, 64'd0);
        check("rst_ready", 64'(wb.in_ready), 64'd1);
        check("rst_halted", 64'(wb.halted), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        check("rst_retired", retired, 64'd0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].valid, vecs[i].instr, vecs[i].rd, vecs[i].alu_c,
                  vecs[i].flag, vecs[i].addrch, vecs[i].naddr);
            check($sformatf("v%0d_we", i), 64'(wb.rf_we), 64'(vecs[i].e_we));
            check($sformatf("v%0d_waddr", i), 64'(wb.rf_waddr), 64'(vecs[i].e_waddr));
            check($sformatf("v%0d_wdata", i), wb.rf_wdata, vecs[i].e_wdata);
            check($sformatf("v%0d_pc", i), wb.pc, vecs[i].e_pc);
            check($sformatf("v%0d_f1", i), 64'(wb.flag_f1), 64'(vecs[i].e_f1));
            check($sformatf("v%0d_f2", i), 64'(wb.flag_f2), 64'(vecs[i].e_f2));
            check($sformatf("v%0d_ready", i), 64'(wb.in_ready), 64'(vecs[i].e_ready));
            check($sformatf("v%0d_halted", i), 64'(wb.halted), 64'(vecs[i].e_halted));
            $display("vec %0d: instr=%0d valid=%0d -> we=%0d pc=%h ready=%0d",
                     i, vecs[i].instr, vecs[i].valid, wb.rf_we, wb.pc, wb.in_ready);
        end

        // HALT is sticky: valid bundles keep arriving and are ignored.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 6'd0, 4'd3, 64'h1111, 1'b1, 1'b1, 64'h2000);
            check($sformatf("halt%0d_ready", i), 64'(wb.in_ready), 64'd0);
            check($sformatf("halt%0d_halted", i), 64'(wb.halted), 64'd1);
            check($sformatf("halt%0d_pc", i), wb.pc, 64'h0);
            check($sformatf("halt%0d_we", i), 64'(wb.rf_we), 64'd0);
            $display("halt cycle %0d: pc=%h halted=%0d", i, wb.pc, wb.halted);
        end

        // Reset out of HALT with a valid bundle on the reset edge.
        reset = 1'b1;
        drive(1'b1, 6'd0, 4'd9, 64'h9999, 1'b1, 1'b0, 64'h0);
        reset = 1'b0;
        check("hrst_pc", wb.pc, PC_RST);
        check("hrst_halted", 64'(wb.halted), 64'd0);
        check("hrst_ready", 64'(wb.in_ready), 64'd1);
        check("hrst_we", 64'(wb.rf_we), 64'd0);
        check("hrst_flags", {62'd0, wb.flag_f1, wb.flag_f2}, 64'd0);
        $display("reset from halt: pc=%h halted=%0d ready=%0d", wb.pc, wb.halted, wb.in_ready);
        drive(1'b1, 6'd1, 4'd9, 64'h9999, 1'b0, 1'b0, 64'h0);
        check("post_we", 64'(wb.rf_we), 64'd1);
        check("post_waddr", 64'(wb.rf_waddr), 64'd9);
        check("post_wdata", wb.rf_wdata, 64'h9999);
        check("post_pc", wb.pc, PC_RST + 64'd1);
        $display("first after reset: we=%0d pc=%h", wb.rf_we, wb.pc);

        // Reset out of FLUSH.
        drive(1'b1, 6'd14, 4'd0, 64'h0, 1'b0, 1'b1, 64'h80);
        check("fl_ready", 64'(wb.in_ready), 64'd0);
        reset = 1'b1;
        drive(1'b0, 6'd0, 4'd0, 64'h0, 1'b0, 1'b0, 64'h0);
        reset = 1'b0;
        check("frst_ready", 64'(wb.in_ready), 64'd1);
        check("frst_pc", wb.pc, PC_RST);
        $display("reset from flush: pc=%h ready=%0d", wb.pc, wb.in_ready);

`ifdef WB_RETIRE_CNT_EN
        check("ret_zero", retired, 64'd0);
        drive(1'b1, 6'd0, 4'd1, 64'h1, 1'b0, 1'b0, 64'h0);
        drive(1'b0, 6'd0, 4'd1, 64'h1, 1'b0, 1'b0, 64'h0);
        drive(1'b1, 6'd4, 4'd1, 64'h1, 1'b0, 1'b0, 64'h0);
        drive(1'b1, 6'd14, 4'd1, 64'h1, 1'b0, 1'b1, 64'h200);
        drive(1'b1, 6'd0, 4'd1, 64'h1, 1'b0, 1'b0, 64'h0);
        drive(1'b1, 6'd2, 4'd1, 64'h1, 1'b0, 1'b0, 64'h0);
        drive(1'b0, 6'd0, 4'd1, 64'h1, 1'b0, 1'b0, 64'h0);
        drive(1'b0, 6'd0, 4'd1, 64'h1, 1'b0, 1'b0, 64'h0);
        drive(1'b1, 6'd9, 4'd1, 64'h1, 1'b1, 1'b0, 64'h0);
        check("ret_five", retired, 64'd5);
        check("ret_pc", wb.pc, 64'h202);
        $display("retire sequence: retired=%0d pc=%h", retired, wb.pc);
`endif

        wb.in_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
